// File: rtl/detector_teclas_n.sv
// detector_teclas_n
// Debounces a set of raw key lines coming from a keypad scanner and reports
// one event per accepted key press.
//
// Ports:
//   clk_i             single clock, rising edge
//   reset_i           asynchronous, active-high reset
//   pulso_teclas_i    raw asynchronous key lines (N_LINES wide, active-high)
//   inhibit_o         high while a key is accepted and not yet released;
//                     freezes the scanner
//   data_available_o  one-cycle strobe per accepted key event
//   linea_o           lowest active line index captured at acceptance
//   multi_o           more than one line was active at acceptance
//
// Optional feature: define KEY_REPEAT_EN to emit auto-repeat strobes while a
// key stays held (first after REP_DELAY cycles, then every REP_PERIOD).
// Without the macro REP_DELAY/REP_PERIOD only size the counter.
`timescale 1ns/1ps

module detector_teclas_n #(
    parameter int N_LINES    = 4,
    parameter int DB_CYCLES  = 16,
    parameter int REP_DELAY  = 1000,
    parameter int REP_PERIOD = 250
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [N_LINES-1:0]         pulso_teclas_i,
    output logic                       inhibit_o,
    output logic                       data_available_o,
    output logic [$clog2(N_LINES)-1:0] linea_o,
    output logic                       multi_o
);

    localparam int LINE_W  = $clog2(N_LINES);
    localparam int MAX_DR  = (DB_CYCLES > REP_DELAY) ? DB_CYCLES : REP_DELAY;
    localparam int CNT_MAX = (MAX_DR > REP_PERIOD) ? MAX_DR : REP_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REP_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [N_LINES-1:0] sync_p0, sync_p1;
    logic               any_p1;
    logic               strobe_n;
    logic               capture;
    logic               inhibit_n;
    logic [LINE_W-1:0]  low_idx;
    logic               multi_now;
`ifdef KEY_REPEAT_EN
    // Set once the first repeat has fired; selects REP_PERIOD over REP_DELAY.
    logic               rep_phase, rep_phase_n;
`endif

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_TOP) ? c : c + 1'b1;
    endfunction

    assign any_p1 = |sync_p1;

    // Lowest-numbered active line; scanning downward lets the lowest win.
    always_comb begin
        low_idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (sync_p1[i]) low_idx = LINE_W'(i);
        end
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_now = |(sync_p1 & (sync_p1 - 1'b1));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        strobe_n = 1'b0;
        capture  = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_phase_n = rep_phase;
`endif
        case (state)
            IDLE: begin
                if (any_p1) begin
                    state_n = PRESS_DB;
                    cnt_n   = '0;
                end
            end
            PRESS_DB: begin
                if (!any_p1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n  = HELD;
                    cnt_n    = '0;
                    strobe_n = 1'b1;
                    capture  = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_phase_n = 1'b0;
`endif
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            HELD: begin
                if (!any_p1) begin
                    state_n = RELEASE_DB;
                    cnt_n   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (cnt == (rep_phase ? RP_LAST : RD_LAST)) begin
                        strobe_n    = 1'b1;
                        cnt_n       = '0;
                        rep_phase_n = 1'b1;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
`else
                    cnt_n = cnt;
`endif
                end
            end
            RELEASE_DB: begin
                if (any_p1) begin
                    // Bounce back to held: no strobe, repeat timing restarts.
                    state_n = HELD;
                    cnt_n   = '0;
`ifdef KEY_REPEAT_EN
                    rep_phase_n = 1'b0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign inhibit_n = (state_n == HELD) || (state_n == RELEASE_DB);

    // Stage p0/p1: two-flop synchronizer; FSM and outputs follow sync_p1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_p0          <= '0;
            sync_p1          <= '0;
            state            <= IDLE;
            cnt              <= '0;
            inhibit_o        <= 1'b0;
            data_available_o <= 1'b0;
            linea_o          <= '0;
            multi_o          <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_phase        <= 1'b0;
`endif
        end else begin
            sync_p0          <= pulso_teclas_i;
            sync_p1          <= sync_p0;
            state            <= state_n;
            cnt              <= cnt_n;
            inhibit_o        <= inhibit_n;
            data_available_o <= strobe_n;
            if (capture) begin
                linea_o <= low_idx;
                multi_o <= multi_now;
            end
`ifdef KEY_REPEAT_EN
            rep_phase        <= rep_phase_n;
`endif
        end
    end

endmodule

// File: tb/tb_detector_teclas_n.sv
`timescale 1ns/1ps

module tb_detector_teclas_n;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys;
    logic       inhibit;
    logic       da;
    logic [1:0] linea;
    logic       multi;

    detector_teclas_n #(
        .N_LINES(N), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)
    ) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .pulso_teclas_i  (keys),
        .inhibit_o       (inhibit),
        .data_available_o(da),
        .linea_o         (linea),
        .multi_o         (multi)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: the synchronized stream is the raw input delayed by two
    // edges; acceptance/release are decided by run lengths of that stream.
    logic [3:0] m_d1, m_d2;
    bit         m_down;
    int         ones_run, zeros_run, held_run;
    logic       e_inh, e_da, e_multi;
    logic [1:0] e_line;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_down = 0;
        ones_run = 0; zeros_run = 0; held_run = 0;
        e_inh = 0; e_da = 0; e_multi = 0; e_line = '0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] v;
        v = m_d2; m_d2 = m_d1; m_d1 = raw;
        e_da = 0;
        if (!m_down) begin
            if (|v) begin
                ones_run++;
                // entry sample plus DB stable samples
                if (ones_run == DB + 1) begin
                    m_down = 1; e_da = 1;
                    e_line = lowest(v);
                    e_multi = ($countones(v) > 1);
                    held_run = 0; zeros_run = 0;
                end
            end else begin
                ones_run = 0;
            end
        end else begin
            if (|v) begin
                if (zeros_run > 0) begin
                    zeros_run = 0; held_run = 0;
                end else begin
                    held_run++;
`ifdef KEY_REPEAT_EN
                    if (held_run == RD || (held_run > RD && (held_run - RD) % RP == 0))
                        e_da = 1;
`endif
                end
            end else begin
                zeros_run++;
                if (zeros_run == DB + 1) begin
                    m_down = 0; ones_run = 0; zeros_run = 0;
                end
            end
        end
        e_inh = m_down;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":inhibit"}, 32'(inhibit), 32'(e_inh));
        check({tag, ":strobe"},  32'(da),      32'(e_da));
        check({tag, ":linea"},   32'(linea),   32'(e_line));
        check({tag, ":multi"},   32'(multi),   32'(e_multi));
    endtask

    task automatic tick(input logic [3:0] v, input string tag);
        keys = v;
        @(posedge clk);
        if (rst) model_reset(); else model_edge(v);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        check({tag, ":async_zero"}, 32'({inhibit, da, linea, multi}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int strobes;
        logic [3:0] seg;
        int len;
        rst  = 1'b1;
        keys = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Line 2 from edge 1: strobe only after edge 7.
        for (int k = 1; k <= 9; k++) begin
            tick(4'b0100, "l2_press");
            if (k == 6) check("l2_no_early_strobe", 32'(da), 32'd0);
            if (k == 7) begin
                check("l2_strobe_e7", 32'(da), 32'd1);
                check("l2_linea", 32'(linea), 32'd2);
                check("l2_multi", 32'(multi), 32'd0);
                check("l2_inhibit", 32'(inhibit), 32'd1);
            end
            if (k == 8) check("l2_strobe_one_cycle", 32'(da), 32'd0);
        end
        repeat (10) tick(4'b0000, "l2_release");
        check("l2_released", 32'(inhibit), 32'd0);

        // Short glitch: no strobe, inhibit stays low.
        repeat (3) tick(4'b0010, "glitch");
        strobes = 0;
        for (int k = 0; k < 8; k++) begin
            tick(4'b0000, "glitch_low");
            strobes += int'(da);
        end
        check("glitch_inhibit", 32'(inhibit), 32'd0);
        check("glitch_no_strobe", 32'(strobes), 32'd0);

        // Lines 1 and 3 together, then line 1 dropped.
        for (int k = 1; k <= 8; k++) begin
            tick(4'b1010, "multi_press");
            if (k == 7) begin
                check("multi_strobe", 32'(da), 32'd1);
                check("multi_linea", 32'(linea), 32'd1);
                check("multi_flag", 32'(multi), 32'd1);
            end
        end
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b1000, "multi_drop");
            strobes += int'(da);
        end
`ifndef KEY_REPEAT_EN
        check("multi_drop_no_strobe", 32'(strobes), 32'd0);
`endif
        check("multi_linea_held", 32'(linea), 32'd1);
        repeat (10) tick(4'b0000, "multi_release");

        // Release with a 2-cycle bounce inside the release debounce.
        repeat (9) tick(4'b0001, "bounce_press");
        repeat (3) tick(4'b0000, "bounce_low1");
        repeat (2) tick(4'b0001, "bounce_high");
        strobes = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(4'b0000, "bounce_low2");
            strobes += int'(da);
            // final low is synchronized two edges in; 5 samples later it drops
            if (k == 6) check("bounce_inhibit_still_high", 32'(inhibit), 32'd1);
            if (k == 7) check("bounce_inhibit_low", 32'(inhibit), 32'd0);
        end
        check("bounce_no_strobe", 32'(strobes), 32'd0);

        // Reset during hold, key still pressed afterwards.
        repeat (9) tick(4'b1000, "rst_press");
        pulse_reset("rst_held");
        for (int k = 1; k <= 8; k++) begin
            tick(4'b1000, "rst_repress");
            if (k == 7) begin
                check("rst_new_strobe", 32'(da), 32'd1);
                check("rst_new_linea", 32'(linea), 32'd3);
            end
        end
        repeat (10) tick(4'b0000, "rst_release");

        // Long hold (exercises auto-repeat when enabled).
        strobes = 0;
        for (int k = 1; k <= 7 + 30; k++) begin
            tick(4'b0100, "long_hold");
            strobes += int'(da);
        end
`ifdef KEY_REPEAT_EN
        check("long_hold_strobes", 32'(strobes), 32'd6);
`else
        check("long_hold_strobes", 32'(strobes), 32'd1);
`endif
        check("long_hold_linea", 32'(linea), 32'd2);
        repeat (10) tick(4'b0000, "long_release");

        // Randomized key segments with bounces and occasional resets.
        for (int s = 0; s < 120; s++) begin
            seg = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(1, 15));
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) tick(4'($urandom_range(0, 15)), "rand_bounce");
                else tick(seg, "rand");
            end
            if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
